// File: rtl/enemy_pkg.sv
// Shared widths, spawn type codes, controller state encodings and LFSR/saturation helpers.
// Pure definitions: no latency and no flow control.
package enemy_pkg;

  localparam int POS_W = 9;
  localparam int DMG_W = 8;
  localparam int ACC_W = 11;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } enemy_type_e;

  localparam logic [3:0] ST_IDLE   = 4'b0001;
  localparam logic [3:0] ST_RUN    = 4'b0010;
  localparam logic [3:0] ST_MOVE   = 4'b0100;
  localparam logic [3:0] ST_ATTACK = 4'b1000;

  // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [DMG_W-1:0] sat_dmg(input logic [ACC_W-1:0] a);
    return (a > ACC_W'(255)) ? {DMG_W{1'b1}} : a[DMG_W-1:0];
  endfunction

endpackage

// File: rtl/enemy_wave_ctrl_if.sv
// Bundle of player-side and enemy-slot-side signals around the wave controller.
// Master is the controller; slave is the battlefield side. No flow control.
interface enemy_wave_ctrl_if #(
  parameter int NUM_ENEMIES = 4
);

  logic                                       game_en;
  logic [enemy_pkg::POS_W-1:0]                player_front;
  logic [enemy_pkg::DMG_W-1:0]                player_dmg;
  logic [NUM_ENEMIES-1:0]                     enemy_dead;
  logic [enemy_pkg::POS_W*NUM_ENEMIES-1:0]    enemy_pos;
  logic [enemy_pkg::DMG_W*NUM_ENEMIES-1:0]    enemy_dmg_out;
  logic [NUM_ENEMIES-1:0]                     can_spawn;
  logic [1:0]                                 spawn_type;
  logic                                       move_scen;
  logic                                       damage_scen;
  logic [enemy_pkg::DMG_W*NUM_ENEMIES-1:0]    damage_in;
  logic [enemy_pkg::POS_W-1:0]                unit_front;
  logic [enemy_pkg::DMG_W-1:0]                enemy_dmg_total;
  logic                                       enemy_dmg_valid;

  modport master (
    input  game_en, player_front, player_dmg, enemy_dead, enemy_pos, enemy_dmg_out,
    output can_spawn, spawn_type, move_scen, damage_scen, damage_in,
           unit_front, enemy_dmg_total, enemy_dmg_valid
  );

  modport slave (
    output game_en, player_front, player_dmg, enemy_dead, enemy_pos, enemy_dmg_out,
    input  can_spawn, spawn_type, move_scen, damage_scen, damage_in,
           unit_front, enemy_dmg_total, enemy_dmg_valid
  );

endinterface

// File: rtl/enemy_front_sel.sv
// Picks the alive slot with the largest position, lowest index on ties.
// Combinational, zero latency; no flow control.
module enemy_front_sel
  import enemy_pkg::*;
#(
  parameter int NUM_ENEMIES = 4
) (
  input  logic [NUM_ENEMIES-1:0]       dead,
  input  logic [POS_W*NUM_ENEMIES-1:0] pos,
  output logic                         front_vld,
  output logic [2:0]                   front_idx
);

  logic [POS_W-1:0] best_pos;

  // Strict greater-than keeps the earlier (lower) index when positions tie.
  always_comb begin
    front_vld = 1'b0;
    front_idx = '0;
    best_pos  = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (!dead[i] && (!front_vld || pos[POS_W*i +: POS_W] > best_pos)) begin
        front_vld = 1'b1;
        front_idx = 3'(i);
        best_pos  = pos[POS_W*i +: POS_W];
      end
    end
  end

endmodule

// File: rtl/enemy_wave_ctrl.sv
// Enemy wave controller: tick FSM, move/damage strobes, spawn scheduling, damage routing.
// Strobes/spawn are same-cycle decodes of state; totals and unit_front lag one cycle; no backpressure.
module enemy_wave_ctrl
  import enemy_pkg::*;
#(
  parameter int         NUM_ENEMIES = 4,
  parameter int         TICK_DIV    = 1000,
  parameter int         SPAWN_DIV   = 8,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input logic               clk,
  input logic               reset,
  enemy_wave_ctrl_if.master bus
);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int SPAWN_W = $clog2(SPAWN_DIV + 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_DIV - 1);

  logic [3:0]             state;
  logic [3:0]             state_nxt;
  logic [TICK_W-1:0]      tick_cnt;
  logic [SPAWN_W-1:0]     spawn_cnt;
  logic [7:0]             lfsr;
  logic [1:0]             lockout;
  logic                   tick_done;
  logic                   spawn_go;
  logic                   any_dead;
  logic [NUM_ENEMIES-1:0] low_dead;
  logic                   front_vld;
  logic [2:0]             front_idx;
  logic [ACC_W-1:0]       alive_sum;

  enemy_front_sel #(
    .NUM_ENEMIES(NUM_ENEMIES)
  ) u_front_sel (
    .dead      (bus.enemy_dead),
    .pos       (bus.enemy_pos),
    .front_vld (front_vld),
    .front_idx (front_idx)
  );

  assign tick_done = (tick_cnt == TICK_LAST);

  always_comb begin
    any_dead = 1'b0;
    low_dead = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (bus.enemy_dead[i] && !any_dead) begin
        any_dead    = 1'b1;
        low_dead[i] = 1'b1;
      end
    end
  end

  // Lockout spans the slot deploy latency while its dead flag is still set.
  assign spawn_go = (state == ST_RUN) && (lockout == 2'd0) &&
                    (spawn_cnt == SPAWN_LAST) && any_dead;

  always_comb begin
    alive_sum = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (!bus.enemy_dead[i]) begin
        alive_sum = alive_sum + ACC_W'(bus.enemy_dmg_out[DMG_W*i +: DMG_W]);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.game_en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!bus.game_en)   state_nxt = ST_IDLE;
        else if (tick_done) state_nxt = ST_MOVE;
      end
      ST_MOVE:   state_nxt = ST_ATTACK;
      ST_ATTACK: state_nxt = bus.game_en ? ST_RUN : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      spawn_cnt <= '0;
      lfsr      <= LFSR_SEED;
      lockout   <= 2'd0;
    end else begin
      state <= state_nxt;

      if (state == ST_RUN && bus.game_en && !tick_done) tick_cnt <= tick_cnt + 1'b1;
      else                                              tick_cnt <= '0;

      if (spawn_go || (state == ST_RUN && !bus.game_en)) spawn_cnt <= '0;
      else if (state == ST_MOVE && spawn_cnt != SPAWN_LAST) spawn_cnt <= spawn_cnt + 1'b1;

      if (spawn_go) lfsr <= lfsr_next(lfsr);

      if (spawn_go)                lockout <= 2'd3;
      else if (lockout != 2'd0)    lockout <= lockout - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.unit_front      <= '0;
      bus.enemy_dmg_total <= '0;
      bus.enemy_dmg_valid <= 1'b0;
    end else begin
      bus.unit_front      <= bus.player_front;
      bus.enemy_dmg_valid <= (state == ST_ATTACK);
      if (state == ST_ATTACK) bus.enemy_dmg_total <= sat_dmg(alive_sum);
    end
  end

  assign bus.move_scen   = (state == ST_MOVE);
  assign bus.damage_scen = (state == ST_ATTACK);
  assign bus.can_spawn   = spawn_go ? low_dead : '0;
  assign bus.spawn_type  = spawn_go ? lfsr[1:0] : 2'(NONE);

  // Slots compare health against damage_in every cycle, so it must stay zero outside ATTACK.
  always_comb begin
    bus.damage_in = '0;
    if (state == ST_ATTACK && front_vld) begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        if (front_idx == 3'(i)) bus.damage_in[DMG_W*i +: DMG_W] = bus.player_dmg;
      end
    end
  end

endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// Directed table/sequence checks on a fast-spawn instance, then random traffic against a model.
module tb_enemy_wave_ctrl;

  localparam int TD = 5;
  localparam int SD = 3;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  enemy_wave_ctrl_if #(.NUM_ENEMIES(4)) ifa ();
  enemy_wave_ctrl_if #(.NUM_ENEMIES(4)) ifb ();

  enemy_wave_ctrl #(.NUM_ENEMIES(4), .TICK_DIV(4), .SPAWN_DIV(1), .LFSR_SEED(8'hA5))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  enemy_wave_ctrl #(.NUM_ENEMIES(4), .TICK_DIV(TD), .SPAWN_DIV(SD), .LFSR_SEED(8'hA5))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dead;
    logic [35:0] pos;
    logic [31:0] dmg;
    logic [7:0]  pd;
    logic [31:0] din;
    logic [7:0]  tot;
  } vec_t;

  vec_t vecs [7];

  // reference model state for dut_b
  bit          m_run;
  int          m_ph;
  int          m_moves;
  int          m_lock;
  logic [7:0]  m_lfsr;
  int          m_tot;
  bit          m_vld;
  logic [8:0]  m_uf;
  logic [3:0]  rd;
  logic [35:0] rp;
  logic [31:0] rdm;
  logic [7:0]  rpd;
  logic        rge;
  logic [3:0]  e_cs;
  logic [1:0]  e_ty;
  logic [31:0] e_din;
  int          ld, f, best, sum;
  bit          in_run, in_move, in_att, go;

  function automatic logic [35:0] pk9(logic [8:0] a, logic [8:0] b, logic [8:0] c, logic [8:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] pk8(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
    return {d, c, b, a};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_move();
    bit seen;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc();
      #1;
      if (ifa.move_scen) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_move: got no move_scen want pulse within 30 cycles");
    end
  endtask

  task automatic set_a(logic [3:0] d, logic [35:0] p, logic [31:0] dm, logic [7:0] pd);
    ifa.enemy_dead    = d;
    ifa.enemy_pos     = p;
    ifa.enemy_dmg_out = dm;
    ifa.player_dmg    = pd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    clk = 0; reset = 0;
    ifa.game_en = 1; ifa.player_front = 9'h123;
    set_a(4'b0000, '0, '0, 8'd0);
    ifb.game_en = 0; ifb.player_front = '0; ifb.player_dmg = '0;
    ifb.enemy_dead = '0; ifb.enemy_pos = '0; ifb.enemy_dmg_out = '0;

    vecs[0] = '{4'b0000, pk9(9'd10, 9'd40, 9'd40, 9'd5), pk8(8'd200, 8'd100, 8'd0, 8'd0),
                8'd20, 32'h0000_1400, 8'd255};
    vecs[1] = '{4'b1100, pk9(9'd10, 9'd40, 9'd40, 9'd5), pk8(8'd100, 8'd50, 8'd77, 8'd88),
                8'd20, 32'h0000_1400, 8'd150};
    vecs[2] = '{4'b0100, pk9(9'd100, 9'd50, 9'd300, 9'd300), pk8(8'd10, 8'd20, 8'd30, 8'd40),
                8'd7, 32'h0700_0000, 8'd70};
    vecs[3] = '{4'b1111, pk9(9'd1, 9'd2, 9'd3, 9'd4), pk8(8'd9, 8'd9, 8'd9, 8'd9),
                8'd99, 32'h0000_0000, 8'd0};
    vecs[4] = '{4'b0001, pk9(9'd511, 9'd511, 9'd0, 9'd0), pk8(8'd255, 8'd255, 8'd255, 8'd255),
                8'd255, 32'h0000_FF00, 8'd255};
    vecs[5] = '{4'b0000, pk9(9'd7, 9'd7, 9'd7, 9'd7), pk8(8'd50, 8'd60, 8'd70, 8'd74),
                8'd1, 32'h0000_0001, 8'd254};
    vecs[6] = '{4'b1110, pk9(9'd0, 9'd0, 9'd0, 9'd0), pk8(8'd12, 8'd200, 8'd200, 8'd200),
                8'd33, 32'h0000_0021, 8'd12};

    // reset state and first-tick latency
    repeat (3) cyc();
    #1;
    chk("rst_can_spawn", 64'(ifa.can_spawn), 64'd0);
    chk("rst_spawn_type", 64'(ifa.spawn_type), 64'd0);
    chk("rst_move", 64'(ifa.move_scen), 64'd0);
    chk("rst_damage", 64'(ifa.damage_scen), 64'd0);
    chk("rst_damage_in", 64'(ifa.damage_in), 64'd0);
    chk("rst_unit_front", 64'(ifa.unit_front), 64'd0);
    chk("rst_total", 64'(ifa.enemy_dmg_total), 64'd0);
    chk("rst_valid", 64'(ifa.enemy_dmg_valid), 64'd0);
    reset = 1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      #1;
      chk($sformatf("t1_move_c%0d", k), 64'(ifa.move_scen), 64'(k == 5));
      chk($sformatf("t1_damage_c%0d", k), 64'(ifa.damage_scen), 64'(k == 6));
      if (k == 1) chk("t1_unit_front", 64'(ifa.unit_front), 64'h123);
    end

    // table: front selection, damage routing, saturating totals
    for (int v = 0; v < 7; v++) begin
      set_a(vecs[v].dead, vecs[v].pos, vecs[v].dmg, vecs[v].pd);
      wait_move();
      chk($sformatf("v%0d_din_move", v), 64'(ifa.damage_in), 64'd0);
      cyc(); #1;
      chk($sformatf("v%0d_damage_scen", v), 64'(ifa.damage_scen), 64'd1);
      chk($sformatf("v%0d_din_attack", v), 64'(ifa.damage_in), 64'(vecs[v].din));
      cyc(); #1;
      chk($sformatf("v%0d_valid", v), 64'(ifa.enemy_dmg_valid), 64'd1);
      chk($sformatf("v%0d_total", v), 64'(ifa.enemy_dmg_total), 64'(vecs[v].tot));
      chk($sformatf("v%0d_din_after", v), 64'(ifa.damage_in), 64'd0);
      cyc(); #1;
      chk($sformatf("v%0d_valid_drop", v), 64'(ifa.enemy_dmg_valid), 64'd0);
    end

    // async reset during MOVE drops strobes at once
    set_a(4'b0000, '0, '0, 8'd0);
    wait_move();
    reset = 0;
    #1;
    chk("rstmid_move", 64'(ifa.move_scen), 64'd0);
    chk("rstmid_damage", 64'(ifa.damage_scen), 64'd0);
    chk("rstmid_total", 64'(ifa.enemy_dmg_total), 64'd0);
    cyc(); #1;
    reset = 1;

    // spawn to lowest dead slot, lockout blocks a repeat
    cyc();
    ifa.enemy_dead = 4'b1111;
    #1;
    chk("t4_spawn_slot0", 64'(ifa.can_spawn), 64'b0001);
    chk("t4_spawn_type0", 64'(ifa.spawn_type), 64'd1);
    for (int k = 2; k <= 3; k++) begin
      cyc(); #1;
      chk($sformatf("t4_lockout_c%0d", k), 64'(ifa.can_spawn), 64'd0);
      chk($sformatf("t4_type_idle_c%0d", k), 64'(ifa.spawn_type), 64'd0);
    end
    cyc();
    ifa.enemy_dead = 4'b1110;
    #1;
    chk("t4_lockout_c4", 64'(ifa.can_spawn), 64'd0);
    cyc(); #1;
    chk("t4_move_c5", 64'(ifa.move_scen), 64'd1);
    chk("t4_no_spawn_move", 64'(ifa.can_spawn), 64'd0);
    cyc(); #1;
    chk("t4_no_spawn_attack", 64'(ifa.can_spawn), 64'd0);
    cyc(); #1;
    chk("t4_spawn_slot1", 64'(ifa.can_spawn), 64'b0010);
    chk("t4_spawn_type1", 64'(ifa.spawn_type), 64'd2);

    // all alive defers, then a death spawns in the next RUN cycle
    for (int k = 8; k <= 13; k++) begin
      cyc();
      ifa.enemy_dead = 4'b0000;
      #1;
      chk($sformatf("t5_alive_c%0d", k), 64'(ifa.can_spawn), 64'd0);
    end
    cyc();
    ifa.enemy_dead = 4'b0100;
    #1;
    chk("t5_spawn_slot2", 64'(ifa.can_spawn), 64'b0100);
    chk("t5_spawn_type", 64'(ifa.spawn_type), 64'd1);

    // game_en drops in MOVE: ATTACK completes, then quiet
    cyc();
    ifa.enemy_dead = 4'b0000;
    wait_move();
    ifa.game_en = 0;
    cyc(); #1;
    chk("t6_attack_completes", 64'(ifa.damage_scen), 64'd1);
    cyc(); #1;
    chk("t6_valid_after", 64'(ifa.enemy_dmg_valid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t6_no_move_%0d", k), 64'(ifa.move_scen), 64'd0);
      chk($sformatf("t6_no_damage_%0d", k), 64'(ifa.damage_scen), 64'd0);
      cyc(); #1;
    end

    // random traffic on the slower instance against the model
    reset = 0;
    cyc(); cyc();
    reset = 1;
    m_run = 0; m_ph = 0; m_moves = 0; m_lock = 0; m_lfsr = 8'hA5;
    m_tot = 0; m_vld = 0; m_uf = '0;
    for (int n = 0; n < 3000; n++) begin
      rge = ($urandom_range(0, 29) != 0);
      for (int i = 0; i < 4; i++) begin
        rd[i] = ($urandom_range(0, 3) == 0);
        rp[9*i +: 9] = ($urandom_range(0, 3) == 0) ? 9'd200 : 9'($urandom_range(0, 511));
        rdm[8*i +: 8] = 8'($urandom);
      end
      rpd = 8'($urandom);
      ifb.game_en = rge; ifb.enemy_dead = rd; ifb.enemy_pos = rp;
      ifb.enemy_dmg_out = rdm; ifb.player_dmg = rpd;
      ifb.player_front = 9'($urandom_range(0, 511));
      #1;
      in_run  = m_run && (m_ph < TD);
      in_move = m_run && (m_ph == TD);
      in_att  = m_run && (m_ph == TD + 1);
      ld = -1; f = -1; best = -1; sum = 0;
      for (int i = 0; i < 4; i++) begin
        if (rd[i] && ld < 0) ld = i;
        if (!rd[i] && int'(rp[9*i +: 9]) > best) begin best = int'(rp[9*i +: 9]); f = i; end
        if (!rd[i]) sum += int'(rdm[8*i +: 8]);
      end
      go = in_run && (m_lock == 0) && (m_moves == SD - 1) && (ld >= 0);
      e_cs = '0; e_ty = '0; e_din = '0;
      if (go) begin e_cs[ld] = 1'b1; e_ty = m_lfsr[1:0]; end
      if (in_att && f >= 0) e_din[8*f +: 8] = rpd;
      chk("rnd_can_spawn", 64'(ifb.can_spawn), 64'(e_cs));
      chk("rnd_spawn_type", 64'(ifb.spawn_type), 64'(e_ty));
      chk("rnd_move", 64'(ifb.move_scen), 64'(in_move));
      chk("rnd_damage", 64'(ifb.damage_scen), 64'(in_att));
      chk("rnd_damage_in", 64'(ifb.damage_in), 64'(e_din));
      chk("rnd_unit_front", 64'(ifb.unit_front), 64'(m_uf));
      chk("rnd_total", 64'(ifb.enemy_dmg_total), 64'(m_tot));
      chk("rnd_valid", 64'(ifb.enemy_dmg_valid), 64'(m_vld));
      m_vld = in_att;
      if (in_att) m_tot = (sum > 255) ? 255 : sum;
      m_uf = ifb.player_front;
      if (go) begin
        m_lock = 3; m_moves = 0;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      end else if (m_lock > 0) m_lock--;
      if (in_move && m_moves < SD - 1) m_moves++;
      if (!m_run) begin
        if (rge) begin m_run = 1; m_ph = 0; end
      end else if (in_run) begin
        if (!rge) begin m_run = 0; m_ph = 0; m_moves = 0; end
        else m_ph++;
      end else if (in_move) begin
        m_ph++;
      end else begin
        m_ph = 0;
        if (!rge) m_run = 0;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
